// File: rtl/rbus_pkg.sv
// Shared definitions for the reconfigurable-bus configuration scheduler.
// Holds the default sizing, the FSM state encoding and a ring-index helper.
package rbus_pkg;

  localparam int RBUS_NUM_BUS = 4;
  localparam int RBUS_TIMEOUT = 255;
  localparam int RBUS_TO_W    = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_WAIT_SET = 3'd2,
    ST_ACK      = 3'd3,
    ST_FINISH   = 3'd4
  } rbus_state_e;

  // Successor of idx on a ring of num_bus entries; works for non-power-of-two sizes.
  function automatic int rbus_next_idx(input int idx, input int num_bus);
    return (idx + 1 >= num_bus) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rbus_rr_arbiter.sv
// Combinational round-robin pick: lowest requesting index at or after ptr,
// wrapping around the ring of NUM_BUS requesters.
module rbus_rr_arbiter #(
  parameter  int NUM_BUS = 4,
  localparam int ID_W    = $clog2(NUM_BUS)
) (
  input  logic [NUM_BUS-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [ID_W-1:0]    grant_id,
  output logic               any_req
);

  logic [ID_W-1:0] idx;

  always_comb begin
    grant_id = '0;
    any_req  = 1'b0;
    idx      = '0;
    for (int i = 0; i < NUM_BUS; i++) begin
      idx = ID_W'((int'(ptr) + i) % NUM_BUS);
      if (!any_req && req[idx]) begin
        any_req  = 1'b1;
        grant_id = idx;
      end
    end
  end

endmodule

// File: rtl/rbus_conf_scheduler.sv
// Serialises configuration requests from NUM_BUS reconfigurable buses:
// round-robin grant, start pulse, bounded wait for load, acknowledge, done.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// IDLE      | waiting for any Req; grant latched into Active_Id on exit
// START     | one-cycle Start_Conf to the granted bus; timer held at 0
// WAIT_SET  | waiting for Set_Conf_Already; timeout returns to IDLE
// ACK       | Conf_Already_Ok held until the bus drops Set_Conf_Already
// FINISH    | one-cycle Done pulse; pointer moves past the served bus
module rbus_conf_scheduler
  import rbus_pkg::*;
#(
  parameter  int NUM_BUS = RBUS_NUM_BUS,
  parameter  int TIMEOUT = RBUS_TIMEOUT,
  parameter  int TO_W    = RBUS_TO_W,
  localparam int ID_W    = $clog2(NUM_BUS)
) (
  input  logic               RBUS_CONF_SCHEDULER_Clk,
  input  logic               RBUS_CONF_SCHEDULER_Reset,
  input  logic [NUM_BUS-1:0] RBUS_CONF_SCHEDULER_Req,
  input  logic [NUM_BUS-1:0] RBUS_CONF_SCHEDULER_Set_Conf_Already,
  input  logic               RBUS_CONF_SCHEDULER_Err_Clr,
  output logic [NUM_BUS-1:0] RBUS_CONF_SCHEDULER_Start_Conf,
  output logic [NUM_BUS-1:0] RBUS_CONF_SCHEDULER_Conf_Already_Ok,
  output logic [NUM_BUS-1:0] RBUS_CONF_SCHEDULER_Done,
  output logic               RBUS_CONF_SCHEDULER_Busy,
  output logic [ID_W-1:0]    RBUS_CONF_SCHEDULER_Active_Id,
  output logic               RBUS_CONF_SCHEDULER_Timeout_Err,
  output logic [ID_W-1:0]    RBUS_CONF_SCHEDULER_Err_Id
);

  rbus_state_e     state_q, state_d;
  logic [ID_W-1:0] active_q, active_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] err_id_q, err_id_d;
  logic [TO_W-1:0] timer_q, timer_d;
  logic            err_q, err_d;

  logic [ID_W-1:0]    grant_id;
  logic               any_req;
  logic [TO_W-1:0]    timer_sat;
  logic [ID_W-1:0]    next_ptr;
  logic               set_sel;
  logic               timer_hit;
  logic [NUM_BUS-1:0] onehot;

  rbus_rr_arbiter #(.NUM_BUS(NUM_BUS)) u_arb (
    .req      (RBUS_CONF_SCHEDULER_Req),
    .ptr      (ptr_q),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  // timer_q counts cycles since Start_Conf and parks at TIMEOUT
  assign timer_hit = (timer_q == TO_W'(TIMEOUT));
  assign timer_sat = timer_hit ? timer_q : timer_q + 1'b1;
  assign next_ptr  = ID_W'(rbus_next_idx(int'(active_q), NUM_BUS));
  assign set_sel   = RBUS_CONF_SCHEDULER_Set_Conf_Already[active_q];

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    ptr_d    = ptr_q;
    timer_d  = timer_q;
    err_id_d = err_id_q;
    err_d    = RBUS_CONF_SCHEDULER_Err_Clr ? 1'b0 : err_q;
    case (state_q)
      ST_IDLE: begin
        timer_d = '0;
        if (any_req) begin
          active_d = grant_id;
          state_d  = ST_START;
        end
      end
      ST_START: begin
        timer_d = timer_sat;
        state_d = ST_WAIT_SET;
      end
      ST_WAIT_SET: begin
        // A bus that loads on the last allowed cycle still gets acknowledged.
        if (set_sel) begin
          state_d = ST_ACK;
        end else if (timer_hit) begin
          err_d    = 1'b1;
          err_id_d = active_q;
          ptr_d    = next_ptr;
          state_d  = ST_IDLE;
        end else begin
          timer_d = timer_sat;
        end
      end
      ST_ACK: begin
        if (!set_sel) state_d = ST_FINISH;
      end
      ST_FINISH: begin
        ptr_d   = next_ptr;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge RBUS_CONF_SCHEDULER_Clk or negedge RBUS_CONF_SCHEDULER_Reset) begin
    if (!RBUS_CONF_SCHEDULER_Reset) begin
      state_q  <= ST_IDLE;
      active_q <= '0;
      ptr_q    <= '0;
      timer_q  <= '0;
      err_q    <= 1'b0;
      err_id_q <= '0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;
      ptr_q    <= ptr_d;
      timer_q  <= timer_d;
      err_q    <= err_d;
      err_id_q <= err_id_d;
    end
  end

  assign onehot = NUM_BUS'(1) << active_q;

  assign RBUS_CONF_SCHEDULER_Start_Conf      = (state_q == ST_START)  ? onehot : '0;
  assign RBUS_CONF_SCHEDULER_Conf_Already_Ok = (state_q == ST_ACK)    ? onehot : '0;
  assign RBUS_CONF_SCHEDULER_Done            = (state_q == ST_FINISH) ? onehot : '0;
  assign RBUS_CONF_SCHEDULER_Busy            = (state_q != ST_IDLE);
  assign RBUS_CONF_SCHEDULER_Active_Id       = active_q;
  assign RBUS_CONF_SCHEDULER_Timeout_Err     = err_q;
  assign RBUS_CONF_SCHEDULER_Err_Id          = err_id_q;

endmodule
